// File: rtl/bp_pkg.sv
// Shared branch-prediction types: address width, fall-through step, in-flight prediction record.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package bp_pkg;

    localparam int ADDR_W          = 12;
    localparam int PC_STEP_DEFAULT = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pred_jump;
        logic [ADDR_W-1:0] pred_addr;
    } pred_entry_t;

    // Sequential fetch address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc, input int step);
        return pc + ADDR_W'(step);
    endfunction

endpackage

// File: rtl/bht_resolve_ctrl_if.sv
// Fetch/EX/BHT-update signal bundle of the branch resolve controller.
// Latency: none (wiring only).
// Backpressure: if_valid/if_ready handshake on the fetch side; EX side is never stalled.
interface bht_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic                        if_valid;
    logic [bp_pkg::ADDR_W-1:0]   if_pc;
    logic                        if_pred_jump;
    logic [bp_pkg::ADDR_W-1:0]   if_pred_addr;
    logic                        if_ready;

    logic                        ex_valid;
    logic                        ex_is_branch;
    logic                        ex_taken;
    logic [bp_pkg::ADDR_W-1:0]   ex_target;

    logic [bp_pkg::ADDR_W-1:0]   bht_insert_ins_addr;
    logic [bp_pkg::ADDR_W-1:0]   bht_insert_ins_next_addr;
    logic                        bht_is_branch;
    logic                        bht_is_suc;

    logic                        flush;
    logic [bp_pkg::ADDR_W-1:0]   redirect_pc;
    logic                        empty_err;
    logic [CNT_W-1:0]            branch_cnt;
    logic [CNT_W-1:0]            mispred_cnt;

    // master = fetch/EX environment, slave = resolve controller
    modport master (
        output if_valid, if_pc, if_pred_jump, if_pred_addr,
        output ex_valid, ex_is_branch, ex_taken, ex_target,
        input  if_ready,
        input  bht_insert_ins_addr, bht_insert_ins_next_addr, bht_is_branch, bht_is_suc,
        input  flush, redirect_pc, empty_err, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_pred_jump, if_pred_addr,
        input  ex_valid, ex_is_branch, ex_taken, ex_target,
        output if_ready,
        output bht_insert_ins_addr, bht_insert_ins_next_addr, bht_is_branch, bht_is_suc,
        output flush, redirect_pc, empty_err, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/pred_fifo.sv
// Generic DEPTH-entry circular FIFO with synchronous clear (clear beats push).
// Latency: head shows the oldest entry combinationally; a push is visible the cycle after.
// Backpressure: none internally; caller must not push when full. Pop on empty is ignored.
module pred_fifo #(
    parameter  int DEPTH    = 4,
    parameter  int W        = 8,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [W-1:0]        push_dat,
    output logic [W-1:0]        head,
    output logic [CNT_BITS-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bht_resolve_ctrl.sv
// Tracks fetch-time predictions in order, resolves them against EX, drives BHT update and flush/redirect.
// Latency: BHT strobe, flush and redirect are registered, one cycle after the EX resolve.
// Backpressure: if_ready drops only when the queue is full and nothing pops; EX is never stalled.
module bht_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_STEP = PC_STEP_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bht_resolve_ctrl_if.slave    bus
);

    localparam int CNT_BITS = $clog2(DEPTH + 1);

    pred_entry_t         push_e;
    pred_entry_t         head_e;
    logic [CNT_BITS-1:0] fifo_count;

    logic                pop_now;
    logic                push_now;
    logic                flush_now;
    logic                if_ready_c;
    logic                q_empty;
    logic                q_full;
    logic [ADDR_W-1:0]   fall_pc;
    logic [ADDR_W-1:0]   pred_pc;
    logic [ADDR_W-1:0]   act_pc;

    logic                is_branch_q;
    logic                is_suc_q;
    logic                flush_q;
    logic [ADDR_W-1:0]   ins_addr_q;
    logic [ADDR_W-1:0]   next_addr_q;
    logic [ADDR_W-1:0]   redirect_q;
    logic                empty_err_q;
    logic [CNT_W-1:0]    branch_cnt_q;
    logic [CNT_W-1:0]    mispred_cnt_q;

    assign q_empty = (fifo_count == '0);
    assign q_full  = (fifo_count == CNT_BITS'(DEPTH));

    assign push_e.pc        = bus.if_pc;
    assign push_e.pred_jump = bus.if_pred_jump;
    assign push_e.pred_addr = bus.if_pred_addr;

    // Resolution of the oldest in-flight entry. A non-branch falls through,
    // so a taken prediction on it is a mispredict like any other.
    always_comb begin
        fall_pc   = next_pc(head_e.pc, PC_STEP);
        pred_pc   = head_e.pred_jump ? head_e.pred_addr : fall_pc;
        act_pc    = (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target : fall_pc;
        pop_now   = bus.ex_valid && !q_empty;
        flush_now = pop_now && (pred_pc != act_pc);
    end

    // A flush empties the queue, so fetch may present again at once; the
    // concurrent wrong-path push is dropped rather than stalled.
    assign if_ready_c = !q_full || pop_now;
    assign push_now   = bus.if_valid && if_ready_c && !flush_now;

    pred_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pred_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_now),
        .pop      (pop_now),
        .clear    (flush_now),
        .push_dat (push_e),
        .head     (head_e),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_branch_q <= 1'b0;
            is_suc_q    <= 1'b0;
            flush_q     <= 1'b0;
            ins_addr_q  <= '0;
            next_addr_q <= '0;
            redirect_q  <= '0;
        end else begin
            is_branch_q <= pop_now && bus.ex_is_branch;
            flush_q     <= flush_now;
            // Target is written even when not taken so the BHT keeps it.
            if (pop_now && bus.ex_is_branch) begin
                ins_addr_q  <= head_e.pc;
                next_addr_q <= bus.ex_target;
                is_suc_q    <= bus.ex_taken;
            end
            if (flush_now) begin
                redirect_q <= act_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_err_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (bus.ex_valid && q_empty) begin
                empty_err_q <= 1'b1;
            end
            if (pop_now && bus.ex_is_branch && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (flush_now && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.if_ready                 = if_ready_c;
    assign bus.bht_is_branch            = is_branch_q;
    assign bus.bht_is_suc               = is_suc_q;
    assign bus.bht_insert_ins_addr      = ins_addr_q;
    assign bus.bht_insert_ins_next_addr = next_addr_q;
    assign bus.flush                    = flush_q;
    assign bus.redirect_pc              = redirect_q;
    assign bus.empty_err                = empty_err_q;
    assign bus.branch_cnt               = branch_cnt_q;
    assign bus.mispred_cnt              = mispred_cnt_q;

endmodule

// File: tb/tb_bht_resolve_ctrl.sv
// Bench for bht_resolve_ctrl: vector table plus directed sequences, BHT/flush strobes checked via scoreboard.
module tb_bht_resolve_ctrl;

    logic clk;
    logic rst_n;

    bht_resolve_ctrl_if #(.CNT_W(16)) bus ();
    bht_resolve_ctrl_if #(.CNT_W(4))  sbus ();

    bht_resolve_ctrl #(.DEPTH(4), .PC_STEP(1), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bht_resolve_ctrl #(.DEPTH(4), .PC_STEP(1), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pc;
        logic        pj;
        logic [11:0] pa;
        logic        br;
        logic        tk;
        logic [11:0] tgt;
        logic        exp_fl;
        logic [11:0] exp_redir;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    typedef struct {
        logic        is_br;
        logic [11:0] ins;
        logic [11:0] nxt;
        logic        suc;
        logic        fl;
        logic [11:0] redir;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic is_br, input logic [11:0] ins, input logic [11:0] nxt,
                           input logic suc, input logic fl, input logic [11:0] redir);
        exp_t e;
        e.is_br = is_br; e.ins = ins; e.nxt = nxt; e.suc = suc; e.fl = fl; e.redir = redir;
        sb.push_back(e);
    endtask

    // Strobe monitor: every BHT update or flush must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.bht_is_branch || bus.flush)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'({bus.bht_is_branch, bus.flush}), 0);
            end else begin
                e = sb.pop_front();
                chk("sb_is_branch", 32'(bus.bht_is_branch), 32'(e.is_br));
                chk("sb_flush", 32'(bus.flush), 32'(e.fl));
                if (e.is_br) begin
                    chk("sb_ins_addr", 32'(bus.bht_insert_ins_addr), 32'(e.ins));
                    chk("sb_next_addr", 32'(bus.bht_insert_ins_next_addr), 32'(e.nxt));
                    chk("sb_is_suc", 32'(bus.bht_is_suc), 32'(e.suc));
                end
                if (e.fl) begin
                    chk("sb_redirect", 32'(bus.redirect_pc), 32'(e.redir));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_pred_jump = 1'b0; bus.if_pred_addr = '0;
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0;
        sbus.if_valid = 1'b0; sbus.if_pc = '0; sbus.if_pred_jump = 1'b0; sbus.if_pred_addr = '0;
        sbus.ex_valid = 1'b0; sbus.ex_is_branch = 1'b0; sbus.ex_taken = 1'b0; sbus.ex_target = '0;
    endtask

    initial begin
        logic [11:0] pc;

        //          pc      pj    pa      br    tk    tgt     fl    redir   bc mc
        vecs[0] = '{12'h010, 1'b0, 12'h000, 1'b1, 1'b0, 12'h040, 1'b0, 12'h000, 1, 0};
        vecs[1] = '{12'h020, 1'b1, 12'h050, 1'b1, 1'b1, 12'h050, 1'b0, 12'h000, 2, 0};
        vecs[2] = '{12'h020, 1'b1, 12'h050, 1'b1, 1'b0, 12'h050, 1'b1, 12'h021, 3, 1};
        vecs[3] = '{12'hFFF, 1'b1, 12'h200, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 3, 2};
        vecs[4] = '{12'h030, 1'b0, 12'h000, 1'b1, 1'b1, 12'h080, 1'b1, 12'h080, 4, 3};
        vecs[5] = '{12'h040, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 4, 3};
        vecs[6] = '{12'h050, 1'b1, 12'h060, 1'b1, 1'b1, 12'h070, 1'b1, 12'h070, 5, 4};
        vecs[7] = '{12'h7FF, 1'b0, 12'h000, 1'b1, 1'b1, 12'h800, 1'b0, 12'h000, 6, 4};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_if_ready", 32'(bus.if_ready), 1);
        chk("rst_is_branch", 32'(bus.bht_is_branch), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_redirect", 32'(bus.redirect_pc), 0);
        chk("rst_ins_addr", 32'(bus.bht_insert_ins_addr), 0);
        chk("rst_next_addr", 32'(bus.bht_insert_ins_next_addr), 0);
        chk("rst_is_suc", 32'(bus.bht_is_suc), 0);
        chk("rst_empty_err", 32'(bus.empty_err), 0);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 0);
        chk("rst_mispred_cnt", 32'(bus.mispred_cnt), 0);
        rst_n = 1'b1;

        // Table: one push then its resolve; counters checked after each.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.if_valid = 1'b1; bus.if_pc = vecs[i].pc;
            bus.if_pred_jump = vecs[i].pj; bus.if_pred_addr = vecs[i].pa;
            @(negedge clk);
            bus.if_valid = 1'b0;
            bus.ex_valid = 1'b1; bus.ex_is_branch = vecs[i].br;
            bus.ex_taken = vecs[i].tk; bus.ex_target = vecs[i].tgt;
            if (vecs[i].br || vecs[i].exp_fl)
                sb_push(vecs[i].br, vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].exp_fl, vecs[i].exp_redir);
            @(negedge clk);
            bus.ex_valid = 1'b0;
            chk($sformatf("vec%0d_branch_cnt", i), 32'(bus.branch_cnt), 32'(vecs[i].exp_bc));
            chk($sformatf("vec%0d_mispred_cnt", i), 32'(bus.mispred_cnt), 32'(vecs[i].exp_mc));
        end

        // Fill to full, then push+pop together, then drain across the wrap.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.if_valid = 1'b1; bus.if_pc = 12'h100 + 12'(k);
            bus.if_pred_jump = 1'b0; bus.if_pred_addr = '0;
        end
        @(negedge clk);
        bus.if_valid = 1'b0;
        #1 chk("full_if_ready", 32'(bus.if_ready), 0);
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0;
        bus.if_valid = 1'b1; bus.if_pc = 12'h104;
        #1 chk("full_pop_if_ready", 32'(bus.if_ready), 1);
        @(negedge clk);
        bus.ex_valid = 1'b0; bus.if_valid = 1'b0;
        #1 chk("still_full_if_ready", 32'(bus.if_ready), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pc = 12'h100 + 12'(k);
            bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_taken = 1'b0;
            bus.ex_target = 12'h180 + 12'(k);
            sb_push(1'b1, pc, 12'h180 + 12'(k), 1'b0, 1'b0, 12'h000);
        end
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("drain_if_ready", 32'(bus.if_ready), 1);
        chk("drain_branch_cnt", 32'(bus.branch_cnt), 10);

        // Mispredict the oldest of three while fetch pushes: queue cleared, push dropped.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.if_valid = 1'b1; bus.if_pc = 12'h200 + 12'(k); bus.if_pred_jump = 1'b0;
        end
        @(negedge clk);
        bus.if_pc = 12'h2AA;
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_taken = 1'b1; bus.ex_target = 12'h300;
        sb_push(1'b1, 12'h200, 12'h300, 1'b1, 1'b1, 12'h300);
        #1 chk("flush_if_ready", 32'(bus.if_ready), 1);
        @(negedge clk);
        bus.if_valid = 1'b0; bus.ex_valid = 1'b0;
        chk("pre_empty_err", 32'(bus.empty_err), 0);
        @(negedge clk);
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_taken = 1'b0; bus.ex_target = '0;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("empty_err_set", 32'(bus.empty_err), 1);
        chk("empty_branch_cnt", 32'(bus.branch_cnt), 11);
        chk("empty_mispred_cnt", 32'(bus.mispred_cnt), 5);
        @(negedge clk);
        chk("empty_err_sticky", 32'(bus.empty_err), 1);

        // Saturation on the 4-bit build: 17 mispredicted branches.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            sbus.if_valid = 1'b1; sbus.if_pc = 12'h010; sbus.if_pred_jump = 1'b0;
            @(negedge clk);
            sbus.if_valid = 1'b0;
            sbus.ex_valid = 1'b1; sbus.ex_is_branch = 1'b1; sbus.ex_taken = 1'b1; sbus.ex_target = 12'h080;
            @(negedge clk);
            sbus.ex_valid = 1'b0;
            if (k == 7) chk("sat_mid_mispred", 32'(sbus.mispred_cnt), 8);
        end
        chk("sat_mispred_cnt", 32'(sbus.mispred_cnt), 'hF);
        chk("sat_branch_cnt", 32'(sbus.branch_cnt), 'hF);

        // Reset while a strobe is in flight and two entries are still queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.if_valid = 1'b1; bus.if_pc = 12'h400 + 12'(k); bus.if_pred_jump = 1'b0;
        end
        @(negedge clk);
        bus.if_valid = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_taken = 1'b0; bus.ex_target = 12'h600;
        @(posedge clk);
        #2;
        bus.ex_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_is_branch", 32'(bus.bht_is_branch), 0);
        chk("mid_rst_flush", 32'(bus.flush), 0);
        chk("mid_rst_if_ready", 32'(bus.if_ready), 1);
        chk("mid_rst_branch_cnt", 32'(bus.branch_cnt), 0);
        chk("mid_rst_empty_err", 32'(bus.empty_err), 0);
        chk("mid_rst_ins_addr", 32'(bus.bht_insert_ins_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_taken = 1'b0; bus.ex_target = '0;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("post_rst_discard", 32'(bus.empty_err), 1);
        chk("post_rst_branch_cnt", 32'(bus.branch_cnt), 0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
